// File: rtl/sys_time_gen.sv
// System-time generator for the PWM clock domain: lock-gated free-running counter,
// re-basable to an absolute time on a synchronised SYNC rising edge.
module sys_time_gen #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned CYCLE       = 512,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1048576,
    localparam int unsigned CW         = $clog2(CYCLE),
    localparam int unsigned TW         = $clog2(TIMEOUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             locked_i,
    input  logic             sync_i,
    input  logic [WIDTH-1:0] set_time_i,
    input  logic             set_valid_i,
    output logic             set_ready_o,
    output logic [WIDTH-1:0] sys_time_o,
    output logic [CW-1:0]    cycle_cnt_o,
    output logic             cycle_tick_o,
    output logic             running_o,
    output logic             sync_err_o
);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_FREE      = 2'd1,
        S_ARMED     = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       time_q, time_d;
    logic [WIDTH-1:0]       pend_q, pend_d;
    logic [TW-1:0]          to_q, to_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   rise;

    // SYNC is asynchronous: resynchronise, then detect the rising edge one flop later.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sync_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_WAIT_LOCK;
            time_q  <= '0;
            pend_q  <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            pend_q  <= pend_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign set_ready_o = (state_q == S_FREE) & locked_i;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pend_d  = pend_q;
        to_d    = to_q;
        err_d   = err_q;
        if (!locked_i) begin
            // Loss of lock beats everything; the error flag survives it.
            state_d = S_WAIT_LOCK;
            time_d  = '0;
            pend_d  = '0;
        end else begin
            case (state_q)
                S_WAIT_LOCK: state_d = S_FREE;
                S_FREE: begin
                    time_d = time_q + WIDTH'(1);
                    if (set_valid_i) begin
                        pend_d  = set_time_i;
                        to_d    = '0;
                        err_d   = 1'b0;
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (rise) begin
                        time_d  = pend_q;
                        state_d = S_FREE;
                    end else begin
                        time_d = time_q + WIDTH'(1);
                        if (to_q == TW'(TIMEOUT - 1)) begin
                            err_d   = 1'b1;
                            state_d = S_FREE;
                        end else begin
                            to_d = to_q + TW'(1);
                        end
                    end
                end
                default: state_d = S_WAIT_LOCK;
            endcase
        end
    end

    assign sys_time_o   = time_q;
    assign cycle_cnt_o  = time_q[CW-1:0];
    assign running_o    = (state_q != S_WAIT_LOCK);
    assign cycle_tick_o = running_o & (cycle_cnt_o == '0);
    assign sync_err_o   = err_q;

endmodule
